// File: rtl/fcf_pkg.sv
// Shared constants and receiver state type for the Fast Cluster Finder deserializer.
package fcf_pkg;
    localparam int FCF_WORD_BITS = 32;
    localparam int FCF_LANE_BITS = 16;

    typedef enum logic [1:0] {
        RESYNC,
        IDLE,
        SHIFT,
        STOP
    } fcf_rx_state_t;
endpackage

// File: rtl/fcf_rx_fifo.sv
// Synchronous FIFO, no read bypass; pop while empty and push while full (no pop) are ignored.
module fcf_rx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [AW-1:0]               wptr_q, rptr_q;
    logic [AW:0]                 level_q;
    logic                        do_push, do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == FULL_LVL);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rptr_q];
    assign level   = level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop)
                rptr_q <= rptr_q + 1'b1;
            level_q <= level_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/fcf_deserializer.sv
// Two-lane FCF frame receiver: framing check, word assembly, output FIFO.
// Define FCF_DESER_STATS_EN to add clear_stats/frame_count/err_count.
module fcf_deserializer
    import fcf_pkg::*;
#(
    parameter int LANE_BITS  = FCF_LANE_BITS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         fs_clk,
    input  logic                         reset_n,
    input  logic                         data_in1,
    input  logic                         data_in2,
    output logic [FCF_WORD_BITS-1:0]     word_out,
    output logic                         word_valid,
    input  logic                         word_ready,
    output logic                         frame_err,
    output logic                         overflow,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
`ifdef FCF_DESER_STATS_EN
    ,
    input  logic                         clear_stats,
    output logic [15:0]                  frame_count,
    output logic [15:0]                  err_count
`endif
);
    localparam int CW = $clog2(LANE_BITS);
    localparam logic [CW-1:0] LAST_BIT = CW'(LANE_BITS - 1);

    logic                 in_q1, in_q2;
    fcf_rx_state_t        state_q;
    logic                 seen_q;
    logic [CW-1:0]        cnt_q;
    logic [LANE_BITS-1:0] sr1_q, sr2_q;
    logic                 frame_err_q, overflow_q;
    logic                 push_d, lane_err_d, overflow_d, fifo_full, fifo_empty;

    // Word is written on the same edge the STOP state sees a clean stop bit.
    assign push_d     = (state_q == STOP) && !in_q1 && !in_q2;
    assign lane_err_d = ((state_q == IDLE) && (in_q1 ^ in_q2)) ||
                        ((state_q == STOP) && (in_q1 || in_q2));
    assign overflow_d = push_d && fifo_full && !(word_valid && word_ready);

    always_ff @(posedge fs_clk or negedge reset_n) begin
        if (!reset_n) begin
            in_q1 <= 1'b0;
            in_q2 <= 1'b0;
        end else begin
            in_q1 <= data_in1;
            in_q2 <= data_in2;
        end
    end

    always_ff @(posedge fs_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RESYNC;
            seen_q      <= 1'b0;
            cnt_q       <= '0;
            sr1_q       <= '0;
            sr2_q       <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            frame_err_q <= lane_err_d;
            overflow_q  <= overflow_d;
            case (state_q)
                RESYNC: begin
                    if (!in_q1 && !in_q2) begin
                        seen_q <= !seen_q;
                        if (seen_q)
                            state_q <= IDLE;
                    end else begin
                        seen_q <= 1'b0;
                    end
                end
                IDLE: begin
                    if (in_q1 && in_q2) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                    end else if (lane_err_d) begin
                        state_q <= RESYNC;
                    end
                end
                SHIFT: begin
                    sr1_q <= {sr1_q[LANE_BITS-2:0], in_q1};
                    sr2_q <= {sr2_q[LANE_BITS-2:0], in_q2};
                    if (cnt_q == LAST_BIT)
                        state_q <= STOP;
                    else
                        cnt_q <= cnt_q + 1'b1;
                end
                STOP:    state_q <= lane_err_d ? RESYNC : IDLE;
                default: state_q <= RESYNC;
            endcase
        end
    end

    fcf_rx_fifo #(
        .WIDTH (FCF_WORD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (fs_clk),
        .rst_n (reset_n),
        .push  (push_d),
        .pop   (word_ready),
        .wdata ({sr1_q, sr2_q}),
        .rdata (word_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign word_valid = !fifo_empty;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

`ifdef FCF_DESER_STATS_EN
    logic [15:0] frame_cnt_q, err_cnt_q;

    // Dropped-on-overflow words still count as good frames.
    always_ff @(posedge fs_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else if (clear_stats) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            if (push_d && frame_cnt_q != 16'hFFFF)
                frame_cnt_q <= frame_cnt_q + 16'd1;
            if (lane_err_d && err_cnt_q != 16'hFFFF)
                err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign frame_count = frame_cnt_q;
    assign err_count   = err_cnt_q;
`endif
endmodule

// File: tb/tb_fcf_deserializer.sv
// Bench for fcf_deserializer: frame-level reference model plus directed and random lane traffic.
module tb_fcf_deserializer;
    localparam int LB    = 16;
    localparam int DEPTH = 4;

    logic        fs_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        data_in1 = 1'b0, data_in2 = 1'b0, word_ready = 1'b0;
    logic [31:0] word_out;
    logic        word_valid, frame_err, overflow;
    logic [2:0]  fifo_level;
`ifdef FCF_DESER_STATS_EN
    logic        clear_stats = 1'b0;
    logic [15:0] frame_count, err_count;
`endif

    always #5 fs_clk = ~fs_clk;

    fcf_deserializer #(.LANE_BITS(LB), .FIFO_DEPTH(DEPTH)) dut (
        .fs_clk      (fs_clk),
        .reset_n     (reset_n),
        .data_in1    (data_in1),
        .data_in2    (data_in2),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .frame_err   (frame_err),
        .overflow    (overflow),
        .fifo_level  (fifo_level)
`ifdef FCF_DESER_STATS_EN
        ,
        .clear_stats (clear_stats),
        .frame_count (frame_count),
        .err_count   (err_count)
`endif
    );

    int checks = 0, errors = 0;

    // Model: pos -3/-2 = waiting for idle samples, -1 = idle, 0..LB-1 = data bits seen, LB = stop due.
    logic [31:0] exp_q[$];
    logic [31:0] got[$];
    int  pos, hi, lo, m_fc, m_ec, n_ferr, n_ovf;
    bit  mq1, mq2, m_ferr, m_ovf, rand_rdy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pos = -3; hi = 0; lo = 0; mq1 = 0; mq2 = 0;
        m_ferr = 0; m_ovf = 0; m_fc = 0; m_ec = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        bit s1, s2, pop_now, push_now;
        logic [31:0] w;
        s1 = mq1; s2 = mq2; push_now = 0;
        pop_now = (exp_q.size() != 0) && word_ready;
        m_ferr = 0; m_ovf = 0;
        if (pos == -3 || pos == -2) begin
            pos = (s1 || s2) ? -3 : pos + 1;
        end else if (pos == -1) begin
            if (s1 && s2) begin pos = 0; hi = 0; lo = 0; end
            else if (s1 || s2) begin m_ferr = 1; pos = -3; end
        end else if (pos < LB) begin
            hi = (hi * 2 + int'(s1)) % 65536;
            lo = (lo * 2 + int'(s2)) % 65536;
            pos++;
        end else begin
            if (!s1 && !s2) begin push_now = 1; pos = -1; end
            else begin m_ferr = 1; pos = -3; end
        end
        if (pop_now) got.push_back(exp_q.pop_front());
        if (push_now) begin
            w = {hi[15:0], lo[15:0]};
            if (exp_q.size() < DEPTH) exp_q.push_back(w);
            else begin m_ovf = 1; n_ovf++; end
        end
        if (m_ferr) n_ferr++;
`ifdef FCF_DESER_STATS_EN
        if (clear_stats) begin m_fc = 0; m_ec = 0; end
        else begin
            if (push_now && m_fc < 65535) m_fc++;
            if (m_ferr && m_ec < 65535) m_ec++;
        end
`endif
        mq1 = data_in1; mq2 = data_in2;
    endtask

    task automatic compare();
        chk("word_valid", {31'b0, word_valid}, {31'b0, exp_q.size() != 0});
        chk("fifo_level", {29'b0, fifo_level}, exp_q.size());
        if (exp_q.size() != 0) chk("word_out", word_out, exp_q[0]);
        chk("frame_err", {31'b0, frame_err}, {31'b0, m_ferr});
        chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
`ifdef FCF_DESER_STATS_EN
        chk("frame_count", {16'b0, frame_count}, m_fc);
        chk("err_count", {16'b0, err_count}, m_ec);
`endif
    endtask

    // Called at a negedge: drive, let the edge happen, advance model, compare at next negedge.
    task automatic tick(input bit b1, input bit b2);
        data_in1 = b1; data_in2 = b2;
        if (rand_rdy) word_ready = ($urandom_range(0, 1) == 1);
`ifdef FCF_DESER_STATS_EN
        if (rand_rdy) clear_stats = ($urandom_range(0, 31) == 0);
`endif
        @(posedge fs_clk);
        if (reset_n) model_step();
        @(negedge fs_clk);
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0);
    endtask

    task automatic data(input logic [31:0] w);
        for (int i = LB - 1; i >= 0; i--) tick(w[16 + i], w[i]);
    endtask

    task automatic send(input logic [31:0] w);
        tick(1, 1); data(w); tick(0, 0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_valid"}, {31'b0, word_valid}, 32'd0);
        chk({tag, "_level"}, {29'b0, fifo_level}, 32'd0);
        chk({tag, "_word"}, word_out, 32'd0);
        chk({tag, "_ferr"}, {31'b0, frame_err}, 32'd0);
        chk({tag, "_ovf"}, {31'b0, overflow}, 32'd0);
`ifdef FCF_DESER_STATS_EN
        chk({tag, "_fcnt"}, {16'b0, frame_count}, 32'd0);
        chk({tag, "_ecnt"}, {16'b0, err_count}, 32'd0);
`endif
    endtask

    initial begin
        logic [31:0] ws[DEPTH+1];
        logic [31:0] wn;
        int g, o0, e0, r, r2;
        model_reset();
        n_ferr = 0; n_ovf = 0; rand_rdy = 0;
        repeat (3) @(negedge fs_clk);
        reset_checks("reset");
        reset_n = 1'b1;
        idle(2);

        // Back-to-back good frames with the consumer always ready.
        word_ready = 1;
        tick(1, 1); data(32'hDEADBEEF); tick(0, 0);
        chk("t1_valid_at_stop", {31'b0, word_valid}, 32'd0);
        tick(1, 1);
        chk("t1_valid_stop+2", {31'b0, word_valid}, 32'd1);
        chk("t1_word0", word_out, 32'hDEADBEEF);
        data(32'h00010002); tick(0, 0);
        tick(0, 0);
        chk("t1_word1", word_out, 32'h00010002);
        idle(2);
        chk("t1_got_n", got.size(), 32'd2);
        chk("t1_got0", got[0], 32'hDEADBEEF);
        chk("t1_got1", got[1], 32'h00010002);
        chk("t1_nferr", n_ferr, 32'd0);

        // Start bit on lane 1 only.
        e0 = n_ferr;
        tick(1, 0); tick(0, 0);
        chk("t2_ferr_pulse", {31'b0, frame_err}, 32'd1);
        tick(0, 0);
        chk("t2_ferr_low", {31'b0, frame_err}, 32'd0);
        chk("t2_nferr", n_ferr, e0 + 1);
        g = got.size();
        send(32'hA5A5_1234); idle(3);
        chk("t2_got_n", got.size(), g + 1);
        chk("t2_word", got[$], 32'hA5A5_1234);

        // Bad stop bit on lane 2.
        word_ready = 0;
        send(32'h1111_2222); idle(1);
        tick(1, 1); data(32'h3333_4444); tick(0, 1); tick(0, 0);
        chk("t3_ferr", {31'b0, frame_err}, 32'd1);
        chk("t3_level", {29'b0, fifo_level}, 32'd1);
        idle(2);
        send(32'h5555_6666); idle(1);
        word_ready = 1; idle(3);
        chk("t3_first", got[$-1], 32'h1111_2222);
        chk("t3_second", got[$], 32'h5555_6666);

        // Overflow: DEPTH+1 frames with no consumer.
        word_ready = 0; idle(1);
        for (int i = 0; i <= DEPTH; i++) ws[i] = $urandom;
        o0 = n_ovf;
        for (int i = 0; i <= DEPTH; i++) send(ws[i]);
        tick(0, 0);
        chk("t4_ovf_pulse", {31'b0, overflow}, 32'd1);
        chk("t4_level", {29'b0, fifo_level}, DEPTH);
        chk("t4_novf", n_ovf, o0 + 1);
        g = got.size();
        word_ready = 1; idle(DEPTH + 1); word_ready = 0;
        chk("t4_drain_n", got.size(), g + DEPTH);
        for (int i = 0; i < DEPTH; i++) chk("t4_drain", got[g + i], ws[i]);

        // Full FIFO with a pop on the push edge.
        for (int i = 0; i < DEPTH; i++) ws[i] = $urandom;
        wn = $urandom;
        for (int i = 0; i < DEPTH; i++) send(ws[i]);
        g = got.size();
        tick(1, 1); data(wn); tick(0, 0);
        word_ready = 1; tick(0, 0); word_ready = 0;
        chk("t5_no_ovf", {31'b0, overflow}, 32'd0);
        chk("t5_level", {29'b0, fifo_level}, DEPTH);
        word_ready = 1; idle(DEPTH + 1); word_ready = 0;
        chk("t5_first", got[g], ws[0]);
        chk("t5_last", got[$], wn);
        chk("t5_n", got.size(), g + DEPTH + 1);

        // Reset in the middle of a frame, then one error and one good frame.
        send(32'h0BAD_F00D); idle(1);
        tick(1, 1);
        for (int i = 0; i < 8; i++) tick(1, 0);
        reset_n = 1'b0; model_reset();
        #1;
        reset_checks("midrst");
        @(negedge fs_clk); idle(2);
        reset_n = 1'b1;
        idle(2);
        g = got.size();
        word_ready = 1;
        tick(1, 0); idle(2);
        send(32'hCAFE_0042); idle(3);
        chk("t6_got_n", got.size(), g + 1);
        chk("t6_word", got[$], 32'hCAFE_0042);
`ifdef FCF_DESER_STATS_EN
        chk("t6_fcnt", {16'b0, frame_count}, 32'd1);
        chk("t6_ecnt", {16'b0, err_count}, 32'd1);
        clear_stats = 1; tick(0, 0); clear_stats = 0;
        chk("t6_fcnt_clr", {16'b0, frame_count}, 32'd0);
        chk("t6_ecnt_clr", {16'b0, err_count}, 32'd0);
`endif

        // Random traffic: mostly good frames, some bad stops and skewed starts.
        rand_rdy = 1;
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7) send($urandom);
            else if (r < 9) begin
                r2 = $urandom_range(1, 3);
                tick(1, 1); data($urandom); tick(r2[1], r2[0]);
            end else tick(1, 0);
            idle($urandom_range(0, 3));
        end
        rand_rdy = 0;
`ifdef FCF_DESER_STATS_EN
        clear_stats = 0;
`endif
        word_ready = 1;
        idle(DEPTH + 4);
        chk("end_level", {29'b0, fifo_level}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
